// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of {PC, instruction} pairs between
// fetch and decode, with show-ahead head outputs and a synchronous branch flush.
module if_id_queue #(
  parameter int N     = 64,
  parameter int IW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N-1:0]               imem_addr_F,
  input  logic [IW-1:0]              imem_data_F,
  input  logic                       fetch_valid_F,
  output logic                       fetch_ready_F,
  input  logic                       flush_D,
  output logic [N-1:0]               pc_D,
  output logic [IW-1:0]              instr_D,
  output logic                       valid_D,
  input  logic                       ready_D,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);
  localparam logic [CW-1:0] EMPTY_C   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
  localparam logic [PW-1:0] PTR_ONE_C = PW'(1);

  logic [N-1:0]  pc_mem_r    [DEPTH];
  logic [IW-1:0] instr_mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;
  logic          not_empty_s;
  logic          not_full_s;

  assign not_empty_s   = (count_r != EMPTY_C);
  assign not_full_s    = (count_r < FULL_C);
  // Ready depends only on occupancy, so decode's ready never reaches fetch.
  assign fetch_ready_F = not_full_s;
  assign valid_D       = not_empty_s;
  assign count         = count_r;
  assign push_s        = fetch_valid_F & not_full_s & ~flush_D;
  assign pop_s         = not_empty_s & ready_D & ~flush_D;

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= imem_addr_F;
      instr_mem_r[wr_ptr_r] <= imem_data_F;
    end
  end

  // Pointer and occupancy tracking; flush returns the queue to empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= EMPTY_C;
    end else if (flush_D) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= EMPTY_C;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Show-ahead head entry, forced to zero while the queue is empty.
  always_comb begin
    pc_D    = {N{1'b0}};
    instr_D = {IW{1'b0}};
    if (not_empty_s) begin
      pc_D    = pc_mem_r[rd_ptr_r];
      instr_D = instr_mem_r[rd_ptr_r];
    end else begin
      pc_D    = {N{1'b0}};
      instr_D = {IW{1'b0}};
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: a scoreboard queue holds every pair the
// bench expects to be captured and is compared against the head as decode consumes.
module tb_if_id_queue;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [63:0] imem_addr_F;
  logic [31:0] imem_data_F;
  logic        fetch_valid_F;
  logic        fetch_ready_F;
  logic        flush_D;
  logic [63:0] pc_D;
  logic [31:0] instr_D;
  logic        valid_D;
  logic        ready_D;
  logic [2:0]  count;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  if_id_queue #(.N(64), .IW(32), .DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr_F   (imem_addr_F),
    .imem_data_F   (imem_data_F),
    .fetch_valid_F (fetch_valid_F),
    .fetch_ready_F (fetch_ready_F),
    .flush_D       (flush_D),
    .pc_D          (pc_D),
    .instr_D       (instr_D),
    .valid_D       (valid_D),
    .ready_D       (ready_D),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle from a negedge, update the scoreboard as the edge happens, return at next negedge.
  task automatic cycle(input logic fv, input logic [63:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    logic do_push;
    logic do_pop;
    ent_t e;
    fetch_valid_F = fv;
    imem_addr_F   = pc;
    imem_data_F   = ins;
    ready_D       = rdy;
    flush_D       = fl;
    do_push = fv && (sb.size() < 4) && !fl;
    do_pop  = (sb.size() != 0) && rdy && !fl;
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (do_pop) sb.delete(0);
      if (do_push) begin
        e.pc = pc;
        e.instr = ins;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    fetch_valid_F = 1'b0;
    ready_D       = 1'b0;
    flush_D       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    fetch_valid_F = 1'b1;
    imem_addr_F = 64'h0000_0000_0000_0100;
    imem_data_F = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (valid_D !== 1'b0 || count !== 3'd0 || pc_D !== 64'd0 || instr_D !== 32'd0 || fetch_ready_F !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: valid=%b count=%0d pc=%h instr=%h rdy=%b, required 0 0 0 0 1",
                 i, valid_D, count, pc_D, instr_D, fetch_ready_F);
      end
    end
    fetch_valid_F = 1'b0;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || valid_D !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: count=%0d valid=%b, required 0 0", count, valid_D);
    end
  endtask

  task automatic test_fill();
    logic [31:0] ins [4];
    ins[0] = 32'h8B020020;
    ins[1] = 32'h8B030041;
    ins[2] = 32'hCB040062;
    ins[3] = 32'hF8008023;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fetch_ready_F !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready%0d: got %b, required 1", i, fetch_ready_F);
      end
      cycle(1'b1, 64'(i * 4), ins[i], 1'b0, 1'b0);
    end
    checks++;
    if (count !== 3'd4 || fetch_ready_F !== 1'b0 || pc_D !== 64'd0 || instr_D !== 32'h8B020020) begin
      errors++;
      $display("FAIL fill_full: count=%0d rdy=%b pc=%h instr=%h, required 4 0 0 8b020020",
               count, fetch_ready_F, pc_D, instr_D);
    end
    cycle(1'b1, 64'd16, 32'h1111_2222, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd4 || pc_D !== 64'd0 || fetch_ready_F !== 1'b0) begin
      errors++;
      $display("FAIL fill_hold: count=%0d pc=%h rdy=%b, required 4 0 0", count, pc_D, fetch_ready_F);
    end
  endtask

  task automatic drain_all(input string tag, input int first_pc);
    int i;
    i = 0;
    while (sb.size() != 0 && i < 8) begin
      checks++;
      if (valid_D !== 1'b1 || pc_D !== sb[0].pc || instr_D !== sb[0].instr || pc_D !== 64'(first_pc + 4 * i)) begin
        errors++;
        $display("FAIL %s_head%0d: valid=%b pc=%h instr=%h, required 1 %h %h", tag, i,
                 valid_D, pc_D, instr_D, sb[0].pc, sb[0].instr);
      end
      cycle(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
      i++;
    end
    checks++;
    if (valid_D !== 1'b0 || count !== 3'd0 || pc_D !== 64'd0 || instr_D !== 32'd0) begin
      errors++;
      $display("FAIL %s_empty: valid=%b count=%0d pc=%h instr=%h, required 0 0 0 0",
               tag, valid_D, count, pc_D, instr_D);
    end
  endtask

  task automatic test_drain_wrap();
    drain_all("drain", 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 64'(16 + i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    end
    checks++;
    if (count !== 3'd4 || pc_D !== 64'd16 || instr_D !== 32'hA000_0000) begin
      errors++;
      $display("FAIL wrap_full: count=%0d pc=%h instr=%h, required 4 10 a0000000", count, pc_D, instr_D);
    end
    drain_all("wrap", 16);
  endtask

  task automatic test_push_pop();
    cycle(1'b1, 64'd32, 32'hB000_0020, 1'b0, 1'b0);
    cycle(1'b1, 64'd36, 32'hB000_0024, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (count !== 3'd2 || valid_D !== 1'b1 || pc_D !== sb[0].pc || instr_D !== sb[0].instr
          || pc_D !== 64'(32 + 4 * i)) begin
        errors++;
        $display("FAIL pushpop%0d: count=%0d pc=%h instr=%h, required 2 %h %h",
                 i, count, pc_D, instr_D, sb[0].pc, sb[0].instr);
      end
      cycle(1'b1, 64'(40 + 4 * i), 32'hB000_0000 + 32'(40 + 4 * i), 1'b1, 1'b0);
    end
    drain_all("pp_tail", 56);
  endtask

  task automatic test_flush();
    cycle(1'b1, 64'd52, 32'hC000_0034, 1'b0, 1'b0);
    cycle(1'b1, 64'd56, 32'hC000_0038, 1'b0, 1'b0);
    cycle(1'b1, 64'd60, 32'hC000_003C, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre: count=%0d, required 3", count);
    end
    cycle(1'b1, 64'd40, 32'hC000_0028, 1'b1, 1'b1);
    checks++;
    if (count !== 3'd0 || valid_D !== 1'b0 || fetch_ready_F !== 1'b1 || pc_D !== 64'd0) begin
      errors++;
      $display("FAIL flush_empty: count=%0d valid=%b rdy=%b pc=%h, required 0 0 1 0",
               count, valid_D, fetch_ready_F, pc_D);
    end
    cycle(1'b1, 64'd16, 32'hC000_0010, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd1 || valid_D !== 1'b1 || pc_D !== 64'd16 || instr_D !== 32'hC000_0010) begin
      errors++;
      $display("FAIL flush_target: count=%0d valid=%b pc=%h instr=%h, required 1 1 10 c0000010",
               count, valid_D, pc_D, instr_D);
    end
    drain_all("flush_tail", 16);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 64'd72, 32'hD000_0048, 1'b0, 1'b0);
    cycle(1'b1, 64'd76, 32'hD000_004C, 1'b0, 1'b0);
    cycle(1'b1, 64'd80, 32'hD000_0050, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd3 || pc_D !== 64'd72) begin
      errors++;
      $display("FAIL rstmid_pre: count=%0d pc=%h, required 3 48", count, pc_D);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (valid_D !== 1'b0 || count !== 3'd0 || pc_D !== 64'd0 || fetch_ready_F !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b count=%0d pc=%h rdy=%b, required 0 0 0 1",
               valid_D, count, pc_D, fetch_ready_F);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 64'd96, 32'hD000_0060, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd1 || pc_D !== 64'd96 || instr_D !== 32'hD000_0060) begin
      errors++;
      $display("FAIL rstmid_after: count=%0d pc=%h instr=%h, required 1 60 d0000060", count, pc_D, instr_D);
    end
    drain_all("rstmid_tail", 96);
  endtask

  initial begin
    reset = 1'b0;
    fetch_valid_F = 1'b0;
    imem_addr_F = 64'd0;
    imem_data_F = 32'd0;
    ready_D = 1'b0;
    flush_D = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain_wrap();
    test_push_pop();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and the decode stage of the 64-bit LEGv8 pipeline.
- Captures each fetched {PC, instruction} pair from fetch (imem_addr_F plus instruction-memory data) and presents entries to decode in order through a valid/ready handshake.
- Absorbs decode stalls without losing fetched instructions.
- Discards all queued (wrong-path) instructions when a taken branch is signalled.

Parameters:
- N, 64: PC width in bits.
- IW, 32: instruction width in bits.
- DEPTH, 4: number of entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_addr_F  in  N  PC of the instruction being offered by fetch.
- imem_data_F  in  IW  instruction word read from imem at imem_addr_F.
- fetch_valid_F  in  1  fetch offers a {PC, instruction} pair this cycle.
- fetch_ready_F  out  1  queue accepts a pair this cycle.
- flush_D  in  1  taken branch (PCSrc); discard all entries.
- pc_D  out  N  PC of the head entry.
- instr_D  out  IW  instruction of the head entry.
- valid_D  out  1  head entry is valid.
- ready_D  in  1  decode consumes the head entry this cycle.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage and state:
  - Circular buffer of DEPTH entries {pc, instr}.
  - Write pointer wr_ptr, read pointer rd_ptr, and count.
  - Pointers wrap modulo DEPTH (DEPTH-1 → 0).
- Reset (reset=0, asynchronous):
  - Immediately sets wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: valid_D=0, pc_D=0, instr_D=0, count=0, fetch_ready_F=1.
  - Entry contents need not be cleared.
  - Reset mid-operation discards every entry.
  - Leaving reset is synchronous to the next rising edge.
- Handshake rules:
  - fetch_ready_F = (count < DEPTH), combinational from count only, so there is no combinational path from ready_D.
  - push = fetch_valid_F & fetch_ready_F & ~flush_D.
  - valid_D = (count != 0).
  - pop = valid_D & ready_D & ~flush_D.
- Outputs:
  - Show-ahead: pc_D and instr_D drive the entry at rd_ptr combinationally.
  - When count=0, pc_D and instr_D are forced to 0.
- Latency:
  - A pair pushed at edge k is visible on valid_D/pc_D/instr_D immediately after edge k.
  - There is no same-cycle bypass from the F inputs to the D outputs.
- Updates on each rising edge:
  - push only: write the entry at wr_ptr, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - push and pop together (possible when 0<count<DEPTH): both pointers advance, count unchanged.
- Full (count=DEPTH):
  - fetch_ready_F=0, and fetch must hold its pair.
  - A pop in this cycle frees a slot, but fetch_ready_F stays 0 until the next cycle.
- Empty (count=0): valid_D=0, and ready_D is ignored.
- Flush (synchronous):
  - flush_D=1 at an edge sets wr_ptr=0, rd_ptr=0, count=0.
  - Any simultaneous push or pop is ignored.
  - After the edge: valid_D=0 and fetch_ready_F=1.
  - If reset and flush_D are asserted together, reset wins.
- Arithmetic: count never exceeds DEPTH and never underflows; pointer increments are modulo DEPTH.

Test Plan:
- Reset check:
  - Stimulus: hold reset=0 for 5 cycles with fetch_valid_F=1.
  - Required: valid_D=0, count=0, pc_D=0, instr_D=0, fetch_ready_F=1 throughout.
  - Release reset: nothing was captured.
- Fill to full:
  - Stimulus: push PCs 0,4,8,12 with instr 0x8B020020, 0x8B030041, 0xCB040062, 0xF8008023, ready_D=0.
  - Required: count=4, fetch_ready_F=0, pc_D=0, instr_D=0x8B020020.
  - Push of PC 16 is held and not captured.
- Drain and wrap-around:
  - Stimulus: ready_D=1 and fetch_valid_F=0 until empty; then push PCs 16–28 with ready_D=0.
  - Required: the drain shows pc_D 0,4,8,12 on consecutive cycles, then valid_D=0.
  - After the refill: count=4 with wrapped pointers, and pc_D=16.
- Simultaneous push/pop:
  - Stimulus: count=2, fetch_valid_F=1 and ready_D=1 for 6 cycles.
  - Required: count stays 2, and pc_D advances by 4 every cycle in order.
- Flush:
  - Stimulus: count=3, flush_D=1 for one cycle with fetch_valid_F=1 (PC 40) and ready_D=1.
  - Required: count=0, valid_D=0, PC 40 is not stored.
  - Then a push of PC 16 (branch target) appears as pc_D=16 one edge later.
- Reset mid-operation:
  - Stimulus: count=3, drive reset=0 between clock edges.
  - Required: valid_D=0 and count=0 immediately, with no edge needed.
